// File: rtl/demux3_4b_pkg.sv
// Shared widths and control encodings for the 3-channel, 4-bit demultiplexer.
package demux3_4b_pkg;

  localparam int DATA_W = 4;
  localparam int NUM_CH = 3;

  localparam logic [1:0] CH0 = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] RR  = 2'b11;

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/demux_slot_4b.sv
// One output channel: a data register plus a valid flag.
// The register can be drained and reloaded in the same cycle.
module demux_slot_4b
  import demux3_4b_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  data_t data_i,
  input  logic  ready_i,
  output data_t data_o,
  output logic  valid_o
);

  data_t data_q, data_d;
  logic  valid_q, valid_d;

  // A load wins over a drain, so a simultaneous drain and load keeps valid high.
  always_comb begin
    data_d  = load_i ? data_i : data_q;
    valid_d = load_i | (valid_q & ~ready_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/demux3_4b.sv
// Routes 4-bit words to one of three channels, chosen directly or round-robin.
// Handshake: a word moves when valid & ready are both high at a rising edge; valid never waits on ready.
module demux3_4b
  import demux3_4b_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] control,
  output logic [3:0] output0,
  output logic [3:0] output1,
  output logic [3:0] output2,
  output logic       valid0,
  output logic       valid1,
  output logic       valid2,
  input  logic       ready0,
  input  logic       ready1,
  input  logic       ready2,
  output logic [1:0] rr_ptr
);

  logic [1:0]        dest;
  logic              accept;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0] slot_valid, slot_ready, slot_load;
  data_t             slot_data [NUM_CH];

  assign slot_ready = {ready2, ready1, ready0};

  always_comb begin
    dest = (control == RR) ? rr_ptr_q : control;
  end

  always_comb begin
    in_ready = 1'b0;
    case (dest)
      CH0:     in_ready = ~slot_valid[0] | slot_ready[0];
      CH1:     in_ready = ~slot_valid[1] | slot_ready[1];
      CH2:     in_ready = ~slot_valid[2] | slot_ready[2];
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid & in_ready;

  // The pointer only moves when a round-robin word is actually taken.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && control == RR) begin
      rr_ptr_d = (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) rr_ptr_q <= 2'd0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    assign slot_load[g] = accept && (dest == 2'(g));

    demux_slot_4b u_slot (
      .clk_i   (clock),
      .rst_i   (reset),
      .load_i  (slot_load[g]),
      .data_i  (in_data),
      .ready_i (slot_ready[g]),
      .data_o  (slot_data[g]),
      .valid_o (slot_valid[g])
    );
  end

  assign output0 = slot_data[0];
  assign output1 = slot_data[1];
  assign output2 = slot_data[2];
  assign valid0  = slot_valid[0];
  assign valid1  = slot_valid[1];
  assign valid2  = slot_valid[2];
  assign rr_ptr  = rr_ptr_q;

endmodule

// File: doc/demux3_4b.md
DEMUX3_4B -- requirements
Module: demux3_4b

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit: the single rising-edge clock for all state.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port in_data, input, 4 bits: the source nibble.
REQ-004 The block SHALL have the port in_valid, input, 1 bit: the source presents in_data.
REQ-005 The block SHALL have the port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-006 The block SHALL have the port control, input, 2 bits: destination select; 00→ch0, 01→ch1, 10→ch2, 11→round-robin.
REQ-007 The block SHALL have the ports output0, output1, output2, each an output of 4 bits: the channel data registers.
REQ-008 The block SHALL have the ports valid0, valid1, valid2, each an output of 1 bit: the channel holds undelivered data.
REQ-009 The block SHALL have the ports ready0, ready1, ready2, each an input of 1 bit: the sink takes the channel data this cycle.
REQ-010 The block SHALL have the port rr_ptr, output, 2 bits: the next round-robin channel, range 0..2.

Function
REQ-011 The destination SHALL be combinational from control: codes 00/01/10 select that channel; code 11 selects the channel in rr_ptr.
REQ-012 in_ready SHALL be !valid_d | ready_d for destination channel d; it is combinational from control, rr_ptr, valid_d and ready_d.
REQ-013 An accept SHALL occur on a cycle where in_valid & in_ready.
REQ-014 On an accept, output_d SHALL load in_data at the next clock edge.
REQ-015 On an accept, valid_d SHALL be 1 after that edge; latency from input to output is 1 cycle.
REQ-016 A drain SHALL occur on channel i on a cycle where valid_i & ready_i.
REQ-017 A drain SHALL clear valid_i at the next edge, unless the same cycle also accepts into channel i; in that case valid_i stays 1 and output_i takes the new data (back-to-back, no bubble).
REQ-018 output_i SHALL hold its last value when valid_i is 0; it changes only on an accept into channel i.
REQ-019 Non-destination channels SHALL drain independently in the same cycle as an accept elsewhere.
REQ-020 rr_ptr SHALL advance 0→1→2→0 only on an accept with control==11; it holds in directed modes and on cycles with no accept.
REQ-021 When in_valid is 0, control changes SHALL have no effect on state.
REQ-022 in_data SHALL be ignored when in_valid=0 or in_ready=0; there is no loss and no duplication.
REQ-023 rr_ptr SHALL never take the value 3.
REQ-024 If the selected channel is full and not draining, in_ready SHALL be 0 and the source stalls; other channels' state is unaffected.
REQ-025 ready_i SHALL be ignored while valid_i=0.

Reset
REQ-026 While reset=1 at a clock edge, output0..2 SHALL become 0000, valid0..2 SHALL become 0 and rr_ptr SHALL become 0.
REQ-027 Reset SHALL take priority over any accept or drain in the same cycle, including a transfer in progress (data is discarded).
REQ-028 in_ready SHALL follow REQ-012 during reset; after the reset edge all channels are empty, so in_ready=1.

Structure
REQ-029 The shared package SHALL hold DATA_W=4, NUM_CH=3 and the control encodings CH0=00, CH1=01, CH2=10, RR=11.
REQ-030 The design SHALL use one sub-module, demux_slot_4b, holding one channel (data register and valid flag with load/drain/hold logic), instantiated three times.
REQ-031 The destination decode, in_ready and rr_ptr logic SHALL reside in demux3_4b.

Verification
REQ-032 Directed test: reset asserted then released, all ready=0 → outputs 0000, valids 0, rr_ptr 0, in_ready=1.
REQ-033 Directed test: control=01, in_data=0101, in_valid=1 for 1 cycle → next cycle output1=0101 and valid1=1; with ready1=0 a second word 1111 to ch1 sees in_ready=0 and output1 stays 0101.
REQ-034 Directed test: ch2 holds 1010 with ready2=1 while control=10 sends 0011 in the same cycle → in_ready=1, next cycle output2=0011 and valid2=1 (bubble-free).
REQ-035 Directed test: control=11, words 0001, 0010, 0011, 0100 on consecutive cycles with all ready=1 → they land on ch0, ch1, ch2, ch0 in that order; rr_ptr is 1,2,0,1 after each.
REQ-036 Directed test: control=11 with in_valid=0 for 5 cycles, then control=00 with 2 accepts → rr_ptr stays at its prior value.
REQ-037 Directed test: reset asserted in the same cycle as an accept of 1001 into ch0 → valid0=0, output0=0000 after the edge.
